// File: rtl/ddr3_ctrl_pkg.sv
// Shared DDR3 controller definitions: return-path entry layout and command opcodes.
// Latency: n/a. Backpressure: n/a.
package ddr3_ctrl_pkg;

    localparam int RET_ADDR_W  = 26;
    localparam int RET_DATA_W  = 16;
    localparam int RET_ENTRY_W = RET_ADDR_W + RET_DATA_W;

    // Address layout is {BA[2:0], row[12:0], col[9:0]}.
    typedef struct packed {
        logic [RET_ADDR_W-1:0] addr;
        logic [RET_DATA_W-1:0] data;
    } ret_entry_t;

    localparam logic [1:0] SCR = 2'd1;
    localparam logic [1:0] SCW = 2'd2;

endpackage

// File: rtl/ddr3_fifo_mem.sv
// Return FIFO storage: DEPTH entries, synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller decides when to write.
module ddr3_fifo_mem
    import ddr3_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  ret_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output ret_entry_t       rdata
);

    ret_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ddr3_return_fifo.sv
// Read-return buffer between the DDR3 command processor and the host, FWFT output.
// Latency: a put into an empty FIFO is presented on out_* the following cycle.
// Backpressure: RETURN_full throttles the processor; out_ready stalls the head.
module ddr3_return_fifo
    import ddr3_ctrl_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PTR_W    = 3,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RETURN_put,
    input  logic [RET_ADDR_W-1:0] RETURN_address,
    input  logic [RET_DATA_W-1:0] RETURN_data,
    output logic                  RETURN_full,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RET_ADDR_W-1:0] out_address,
    output logic [RET_DATA_W-1:0] out_data,
    output logic [PTR_W:0]        count,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] AF_CNT    = AF_LEVEL[PTR_W:0];
    localparam logic [PTR_W:0] ONE       = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] rd_ptr_next;
    logic [PTR_W:0] count_next;
    logic           pop;
    logic           push;
    logic           drop;
    logic           bypass;
    logic           load_head;
    ret_entry_t     wr_entry;
    ret_entry_t     mem_rdata;
    ret_entry_t     head_next;

    assign pop  = out_valid && out_ready;
    assign push = RETURN_put && (!RETURN_full || pop);
    assign drop = RETURN_put && RETURN_full && !pop;

    assign rd_ptr_next = pop ? rd_ptr + ONE : rd_ptr;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + ONE;
        end else if (pop && !push) begin
            count_next = count - ONE;
        end
    end

    assign wr_entry.addr = RETURN_address;
    assign wr_entry.data = RETURN_data;

    ddr3_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[PTR_W-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr_next[PTR_W-1:0]),
        .rdata (mem_rdata)
    );

    // When the incoming word is the only thing left after this cycle's pop, it is
    // not in the array yet, so the head register takes it straight from the inputs.
    assign bypass    = push && (wr_ptr == rd_ptr_next);
    assign head_next = bypass ? wr_entry : mem_rdata;
    assign load_head = (pop || !out_valid) && (count_next != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            RETURN_full <= 1'b0;
            almost_full <= 1'b0;
            out_valid   <= 1'b0;
            out_address <= '0;
            out_data    <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            RETURN_full <= (count_next == DEPTH_CNT);
            almost_full <= (count_next >= AF_CNT);
            out_valid   <= (count_next != '0);
            if (load_head) begin
                out_address <= head_next.addr;
                out_data    <= head_next.data;
            end
            if (clear_overflow) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_return_fifo.sv
// Directed bench for ddr3_return_fifo with hand-computed expectations.
module tb_ddr3_return_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        RETURN_put;
    logic [25:0] RETURN_address;
    logic [15:0] RETURN_data;
    logic        RETURN_full;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_address;
    logic [15:0] out_data;
    logic [3:0]  count;
    logic        almost_full;
    logic        overflow;
    logic        clear_overflow;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ddr3_return_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .RETURN_put     (RETURN_put),
        .RETURN_address (RETURN_address),
        .RETURN_data    (RETURN_data),
        .RETURN_full    (RETURN_full),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_address    (out_address),
        .out_data       (out_data),
        .count          (count),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [25:0] a, input logic [15:0] d);
        RETURN_put     = 1'b1;
        RETURN_address = a;
        RETURN_data    = d;
        tick();
        RETURN_put     = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        RETURN_put     = 1'b0;
        RETURN_address = '0;
        RETURN_data    = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(RETURN_full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_addr", 32'(out_address), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Scenario 1: single put, FWFT presentation, then pop.
        put_word(26'h0ABCDE, 16'h1234);
        chk("s1_valid", 32'(out_valid), 32'd1);
        chk("s1_addr", 32'(out_address), 32'h0ABCDE);
        chk("s1_data", 32'(out_data), 32'h1234);
        chk("s1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s1_empty_valid", 32'(out_valid), 32'd0);
        chk("s1_empty_count", 32'(count), 32'd0);

        // Scenario 2: fill to DEPTH, flags track count, drain in order.
        for (int i = 0; i < 8; i++) begin
            put_word(26'(i + 16), 16'(i));
            chk("s2_count", 32'(count), 32'(i + 1));
            chk("s2_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk("s2_full", 32'(RETURN_full), (i == 7) ? 32'd1 : 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("s2_drain_data", 32'(out_data), 32'(i));
            chk("s2_drain_addr", 32'(out_address), 32'(i + 16));
            tick();
            if (i == 0) chk("s2_full_after_pop", 32'(RETURN_full), 32'd0);
        end
        out_ready = 1'b0;
        chk("s2_empty", 32'(out_valid), 32'd0);
        chk("s2_count0", 32'(count), 32'd0);

        // Scenario 3: dropped put while full sets sticky overflow.
        for (int i = 0; i < 8; i++) put_word(26'h100, 16'(16'h0100 + i));
        put_word(26'h3FF, 16'hDEAD);
        chk("s3_count", 32'(count), 32'd8);
        chk("s3_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("s3_drain", 32'(out_data), 32'(16'h0100 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("s3_empty", 32'(out_valid), 32'd0);
        chk("s3_ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("s3_ovf_clear", 32'(overflow), 32'd0);

        // Clear wins over a same-cycle drop.
        for (int i = 0; i < 8; i++) put_word(26'h200, 16'(16'h0200 + i));
        clear_overflow = 1'b1;
        put_word(26'h3FF, 16'hDEAD);
        clear_overflow = 1'b0;
        chk("s3_clear_prio", 32'(overflow), 32'd0);
        chk("s3_clear_count", 32'(count), 32'd8);

        // Scenario 4: put and pop together while full.
        chk("s4_head", 32'(out_data), 32'h0200);
        out_ready = 1'b1;
        put_word(26'h2BE, 16'hBEEF);
        chk("s4_count", 32'(count), 32'd8);
        chk("s4_ovf", 32'(overflow), 32'd0);
        chk("s4_full", 32'(RETURN_full), 32'd1);
        for (int i = 1; i < 8; i++) begin
            chk("s4_drain", 32'(out_data), 32'(16'h0200 + i));
            tick();
        end
        chk("s4_beef", 32'(out_data), 32'hBEEF);
        chk("s4_beef_addr", 32'(out_address), 32'h2BE);
        tick();
        out_ready = 1'b0;
        chk("s4_empty", 32'(count), 32'd0);

        // Scenario 5: streaming at count==1 across pointer wrap.
        put_word(26'h300, 16'h0300);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("s5_head", 32'(out_data), 32'(16'h0300 + k));
            put_word(26'(26'h301 + k), 16'(16'h0301 + k));
            chk("s5_valid", 32'(out_valid), 32'd1);
            chk("s5_count", 32'(count), 32'd1);
        end
        chk("s5_last", 32'(out_data), 32'h0314);
        chk("s5_last_addr", 32'(out_address), 32'h314);
        tick();
        out_ready = 1'b0;
        chk("s5_empty", 32'(out_valid), 32'd0);

        // Scenario 6: asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) put_word(26'h400, 16'(16'h0400 + i));
        chk("s6_pre_count", 32'(count), 32'd5);
        chk("s6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_async_valid", 32'(out_valid), 32'd0);
        chk("s6_async_count", 32'(count), 32'd0);
        chk("s6_async_full", 32'(RETURN_full), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("s6_post_valid", 32'(out_valid), 32'd0);
        put_word(26'h0ABCDE, 16'h1234);
        chk("s6_put_valid", 32'(out_valid), 32'd1);
        chk("s6_put_addr", 32'(out_address), 32'h0ABCDE);
        chk("s6_put_data", 32'(out_data), 32'h1234);
        chk("s6_put_count", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
